// File: rtl/vector_alu.sv
// Lane-wise vector ALU fed by the register file's parallel read ports; computes
// LANES_PER_CYCLE lanes per clock. Define VALU_SAT_EN for signed-saturating VADD/VSUB.
module vector_alu #(
  parameter int LANES           = 16,
  parameter int WIDTH           = 16,
  parameter int LANES_PER_CYCLE = 4
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   Start,
  input  logic [2:0]             Op,
  input  logic [LANES*WIDTH-1:0] OpA_p,
  input  logic [LANES*WIDTH-1:0] OpB_p,
  input  logic [WIDTH-1:0]       Scalar,
  output logic                   Busy,
  output logic                   Done,
  output logic                   WR_p,
  output logic [LANES*WIDTH-1:0] Result_p,
  output logic [WIDTH-1:0]       Result_s,
  output logic [1:0]             o_dbg_state
);

  localparam int VW   = LANES * WIDTH;
  localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LANES - LANES_PER_CYCLE);
  localparam logic [IDXW-1:0] STEP     = IDXW'(LANES_PER_CYCLE);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Handshake: Start is a level request accepted on any edge where the unit is in
  // IDLE or DONE; Done (and WR_p for vector ops) is a single-cycle pulse.
  logic [1:0]       r_state;
  logic [IDXW-1:0]  r_idx;
  logic [2:0]       r_op;
  logic [VW-1:0]    r_a;
  logic [VW-1:0]    r_b;
  logic [WIDTH-1:0] r_scalar;
  logic [VW-1:0]    r_shadow;
  logic [WIDTH-1:0] r_acc;
  logic [VW-1:0]    r_result_p;
  logic [WIDTH-1:0] r_result_s;

  logic             w_capture;
  logic             w_is_red;
  logic [VW-1:0]    w_shadow_next;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_ga [LANES_PER_CYCLE];
  logic [WIDTH-1:0] w_gb [LANES_PER_CYCLE];
  logic [WIDTH-1:0] w_gr [LANES_PER_CYCLE];

  // Reductions reuse the lane datapath: VSUM passes A through, VDOT yields low(A*B).
  function automatic logic [WIDTH-1:0] f_lane(input logic [2:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] s);
    logic signed [WIDTH:0] ssum;
    ssum = '0;
    case (op)
`ifdef VALU_SAT_EN
      3'b000, 3'b001: begin
        if (op == 3'b000) ssum = $signed({a[WIDTH-1], a}) + $signed({b[WIDTH-1], b});
        else              ssum = $signed({a[WIDTH-1], a}) - $signed({b[WIDTH-1], b});
        if (ssum[WIDTH] != ssum[WIDTH-1])
          f_lane = ssum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
          f_lane = ssum[WIDTH-1:0];
      end
`else
      3'b000:  f_lane = a + b;
      3'b001:  f_lane = a - b;
`endif
      3'b010:  f_lane = a & b;
      3'b011:  f_lane = a | b;
      3'b100:  f_lane = a * s;
      3'b101:  f_lane = a * b;
      3'b110:  f_lane = a;
      default: f_lane = a * b;
    endcase
  endfunction

  assign w_capture = Start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_is_red  = r_op[2] & r_op[1];

  always_comb begin
    w_shadow_next = r_shadow;
    w_acc_next    = r_acc;
    for (int j = 0; j < LANES_PER_CYCLE; j++) begin
      w_ga[j] = '0;
      w_gb[j] = '0;
      for (int i = 0; i < LANES; i++) begin
        if (IDXW'(i) == r_idx + IDXW'(j)) begin
          w_ga[j] = r_a[i*WIDTH +: WIDTH];
          w_gb[j] = r_b[i*WIDTH +: WIDTH];
        end
      end
      w_gr[j]    = f_lane(r_op, w_ga[j], w_gb[j], r_scalar);
      w_acc_next = w_acc_next + w_gr[j];
      for (int i = 0; i < LANES; i++) begin
        if (IDXW'(i) == r_idx + IDXW'(j)) w_shadow_next[i*WIDTH +: WIDTH] = w_gr[j];
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_scalar   <= '0;
      r_shadow   <= '0;
      r_acc      <= '0;
      r_result_p <= '0;
      r_result_s <= '0;
    end else if (w_capture) begin
      r_state  <= S_EXEC;
      r_idx    <= '0;
      r_acc    <= '0;
      r_op     <= Op;
      r_a      <= OpA_p;
      r_b      <= OpB_p;
      r_scalar <= Scalar;
    end else begin
      case (r_state)
        S_EXEC: begin
          r_shadow <= w_shadow_next;
          r_acc    <= w_acc_next;
          r_idx    <= r_idx + STEP;
          if (r_idx == LAST_IDX) begin
            r_state <= S_DONE;
            if (w_is_red) r_result_s <= w_acc_next;
            else          r_result_p <= w_shadow_next;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Busy        = (r_state == S_EXEC);
  assign Done        = (r_state == S_DONE);
  assign WR_p        = Done && !w_is_red;
  assign Result_p    = r_result_p;
  assign Result_s    = r_result_s;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vector_alu.sv
// Directed bench for vector_alu: latency, per-op results, ignored Start, back-to-back
// issue and asynchronous abort.
module tb_vector_alu;

  localparam int LANES = 16;
  localparam int WIDTH = 16;
  localparam int VW    = LANES * WIDTH;

  logic             Clk;
  logic             Rst_n;
  logic             Start;
  logic [2:0]       Op;
  logic [VW-1:0]    OpA_p;
  logic [VW-1:0]    OpB_p;
  logic [WIDTH-1:0] Scalar;
  logic             Busy;
  logic             Done;
  logic             WR_p;
  logic [VW-1:0]    Result_p;
  logic [WIDTH-1:0] Result_s;
  logic [1:0]       dbg_state;

  int errors = 0;
  int checks = 0;
  logic [VW-1:0] last_vec;

  vector_alu #(.LANES(LANES), .WIDTH(WIDTH), .LANES_PER_CYCLE(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op), .OpA_p(OpA_p), .OpB_p(OpB_p),
    .Scalar(Scalar), .Busy(Busy), .Done(Done), .WR_p(WR_p), .Result_p(Result_p),
    .Result_s(Result_s), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [VW-1:0] fill(input logic [WIDTH-1:0] v);
    logic [VW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*WIDTH +: WIDTH] = v;
    return r;
  endfunction

  function automatic logic [VW-1:0] ramp_plus(input int k);
    logic [VW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*WIDTH +: WIDTH] = WIDTH'(i + k);
    return r;
  endfunction

  // driver: called 1ns after an edge; returns 1ns after the edge that sampled Start
  task automatic do_start(input logic [2:0] op, input logic [VW-1:0] a,
                          input logic [VW-1:0] b, input logic [WIDTH-1:0] s);
    Start = 1'b1; Op = op; OpA_p = a; OpB_p = b; Scalar = s;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  // bounded wait; lat=99 when Done never arrives
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 99;
    busy_cnt = Busy ? 1 : 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge Clk); #1;
      if (Done) begin lat = k; return; end
      if (Busy) busy_cnt++;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin @(posedge Clk); #1; end
  endtask

  task automatic test_reset;
    Rst_n = 1'b0; Start = 1'b0; Op = '0; OpA_p = '0; OpB_p = '0; Scalar = '0;
    #3;
    checks++; if ({Busy, Done, WR_p} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {Busy, Done, WR_p}); end
    checks++; if (Result_p !== '0) begin errors++; $display("FAIL reset_result_p got=%h exp=0", Result_p); end
    checks++; if (Result_s !== '0) begin errors++; $display("FAIL reset_result_s got=%h exp=0", Result_s); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    #9 Rst_n = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_vadd;
    int lat, bc;
    do_start(3'b000, fill(16'h0001), ramp_plus(0), '0);
    checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL vadd_exec_state got=%0d exp=1", dbg_state); end
    wait_done(lat, bc);
    checks++; if (lat !== 4) begin errors++; $display("FAIL vadd_latency got=%0d exp=4", lat); end
    checks++; if (bc !== 4) begin errors++; $display("FAIL vadd_busy_cycles got=%0d exp=4", bc); end
    checks++; if ({Done, WR_p, Busy} !== 3'b110) begin errors++; $display("FAIL vadd_done_flags got=%b exp=110", {Done, WR_p, Busy}); end
    checks++; if (Result_p !== ramp_plus(1)) begin errors++; $display("FAIL vadd_result got=%h exp=%h", Result_p, ramp_plus(1)); end
    checks++; if (Result_s !== '0) begin errors++; $display("FAIL vadd_scalar_hold got=%h exp=0", Result_s); end
    idle(1);
    checks++; if ({Done, WR_p} !== 2'b00) begin errors++; $display("FAIL vadd_pulse_width got=%b exp=00", {Done, WR_p}); end
    last_vec = ramp_plus(1);
  endtask

  task automatic test_wrap_sat;
    int lat, bc;
    logic [VW-1:0] exp_sub_min, exp_add_max;
`ifdef VALU_SAT_EN
    exp_sub_min = fill(16'h8000); exp_add_max = fill(16'h7FFF);
`else
    exp_sub_min = fill(16'h7FFF); exp_add_max = fill(16'h8000);
`endif
    do_start(3'b001, fill(16'h0000), fill(16'h0001), '0);
    wait_done(lat, bc);
    checks++; if (Result_p !== fill(16'hFFFF)) begin errors++; $display("FAIL vsub_zero got=%h exp=%h", Result_p, fill(16'hFFFF)); end
    idle(1);
    do_start(3'b001, fill(16'h8000), fill(16'h0001), '0);
    wait_done(lat, bc);
    checks++; if (Result_p !== exp_sub_min) begin errors++; $display("FAIL vsub_min got=%h exp=%h", Result_p, exp_sub_min); end
    idle(1);
    do_start(3'b000, fill(16'h7FFF), fill(16'h0001), '0);
    wait_done(lat, bc);
    checks++; if (Result_p !== exp_add_max) begin errors++; $display("FAIL vadd_max got=%h exp=%h", Result_p, exp_add_max); end
    last_vec = exp_add_max;
    idle(1);
  endtask

  task automatic test_logic_mul;
    int lat, bc;
    do_start(3'b010, fill(16'hF0F0), fill(16'hFF00), '0);
    wait_done(lat, bc);
    checks++; if (Result_p !== fill(16'hF000)) begin errors++; $display("FAIL vand got=%h exp=%h", Result_p, fill(16'hF000)); end
    idle(1);
    do_start(3'b011, fill(16'hF0F0), fill(16'hFF00), '0);
    wait_done(lat, bc);
    checks++; if (Result_p !== fill(16'hFFF0)) begin errors++; $display("FAIL vor got=%h exp=%h", Result_p, fill(16'hFFF0)); end
    idle(1);
    do_start(3'b101, fill(16'h1234), fill(16'h0010), '0);
    wait_done(lat, bc);
    checks++; if (Result_p !== fill(16'h2340)) begin errors++; $display("FAIL vmul got=%h exp=%h", Result_p, fill(16'h2340)); end
    idle(1);
    do_start(3'b100, fill(16'h0003), fill(16'h0007), 16'h0005);
    wait_done(lat, bc);
    checks++; if (Result_p !== fill(16'h000F)) begin errors++; $display("FAIL smul got=%h exp=%h", Result_p, fill(16'h000F)); end
    last_vec = fill(16'h000F);
    idle(1);
  endtask

  task automatic test_reduce;
    int lat, bc;
    do_start(3'b110, ramp_plus(0), fill(16'hFFFF), '0);
    wait_done(lat, bc);
    checks++; if (lat !== 4) begin errors++; $display("FAIL vsum_latency got=%0d exp=4", lat); end
    checks++; if (Result_s !== 16'h0078) begin errors++; $display("FAIL vsum got=%h exp=0078", Result_s); end
    checks++; if ({Done, WR_p} !== 2'b10) begin errors++; $display("FAIL vsum_no_write got=%b exp=10", {Done, WR_p}); end
    checks++; if (Result_p !== last_vec) begin errors++; $display("FAIL vsum_vec_hold got=%h exp=%h", Result_p, last_vec); end
    idle(1);
    do_start(3'b111, ramp_plus(0), fill(16'h0002), '0);
    wait_done(lat, bc);
    checks++; if (Result_s !== 16'h00F0) begin errors++; $display("FAIL vdot got=%h exp=00F0", Result_s); end
    idle(1);
    do_start(3'b111, fill(16'h1000), fill(16'h0010), '0);
    wait_done(lat, bc);
    checks++; if (Result_s !== 16'h0000) begin errors++; $display("FAIL vdot_wrap got=%h exp=0000", Result_s); end
    idle(1);
  endtask

  task automatic test_ignore_start;
    int lat, bc;
    do_start(3'b010, fill(16'h0FF0), fill(16'h00FF), '0);
    Start = 1'b1; Op = 3'b011; OpA_p = fill(16'hAAAA); OpB_p = fill(16'h5555);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Start = 1'b0;
    wait_done(lat, bc);
    checks++; if (lat !== 1) begin errors++; $display("FAIL ignore_latency got=%0d exp=1", lat); end
    checks++; if (Result_p !== fill(16'h00F0)) begin errors++; $display("FAIL ignore_result got=%h exp=%h", Result_p, fill(16'h00F0)); end
    idle(1);
    checks++; if ({Busy, Done} !== 2'b00) begin errors++; $display("FAIL ignore_no_queue got=%b exp=00", {Busy, Done}); end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    do_start(3'b000, fill(16'h0005), fill(16'h0006), '0);
    wait_done(lat, bc);
    checks++; if (Result_p !== fill(16'h000B)) begin errors++; $display("FAIL b2b_first got=%h exp=%h", Result_p, fill(16'h000B)); end
    do_start(3'b001, fill(16'h000A), fill(16'h0003), '0);
    checks++; if ({Busy, Done} !== 2'b10) begin errors++; $display("FAIL b2b_reenter got=%b exp=10", {Busy, Done}); end
    wait_done(lat, bc);
    checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_latency got=%0d exp=4", lat); end
    checks++; if (Result_p !== fill(16'h0007)) begin errors++; $display("FAIL b2b_second got=%h exp=%h", Result_p, fill(16'h0007)); end
    idle(1);
  endtask

  task automatic test_abort;
    int lat, bc, seen;
    do_start(3'b000, fill(16'h0001), fill(16'h0001), '0);
    @(posedge Clk); #2;
    Rst_n = 1'b0;
    #1;
    checks++; if ({Busy, Done, WR_p} !== 3'b000) begin errors++; $display("FAIL abort_flags got=%b exp=000", {Busy, Done, WR_p}); end
    checks++; if (Result_p !== '0 || Result_s !== '0) begin errors++; $display("FAIL abort_results got=%h/%h exp=0/0", Result_p, Result_s); end
    #1 Rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin @(posedge Clk); #1; if (Done || WR_p) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
    do_start(3'b000, fill(16'h0002), fill(16'h0003), '0);
    wait_done(lat, bc);
    checks++; if (lat !== 4) begin errors++; $display("FAIL abort_next_latency got=%0d exp=4", lat); end
    checks++; if (Result_p !== fill(16'h0005)) begin errors++; $display("FAIL abort_next_result got=%h exp=%h", Result_p, fill(16'h0005)); end
    idle(1);
  endtask

  initial begin
    last_vec = '0;
    test_reset();
    test_vadd();
    test_wrap_sat();
    test_reduce();
    test_logic_mul();
    test_ignore_start();
    test_back_to_back();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
